csr_access_unit: RTL and testbench

//  Master side of the CSR bank bus: turns one CSR instruction into bus cycles and a response.

---
 rtl/csr_access_unit.sv | 135 +++++++++++++
 tb/tb_csr_access_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// CSR bus master: turns one CSRRW/RS/RC(I) instruction into a read cycle, an optional
// write cycle and a held response, flagging inaccessible or read-only CSRs as illegal.
module csr_access_unit #(
   parameter bit RO_CHECK = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [11:0] req_addr_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [4:0]  req_rs1_idx_i,
   input  logic [31:0] req_rs1_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_illegal_o,
   output logic        csr_en_o,
   output logic [11:0] csr_addr_o,
   output logic [31:0] csr_set_o,
   output logic [31:0] csr_clear_o,
   input  logic        csr_ack_i,
   input  logic [31:0] csr_value_i
);

   // Handshakes: a request transfers on a cycle with req_valid_i && req_ready_o && !flush_i;
   // a response transfers on rsp_valid_o && rsp_ready_i, and rsp_valid_o holds until then.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [11:0] addr_q, addr_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic        illegal_q, illegal_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rd_illegal;

   // funct3[2] only selects the operand source, so only the low bits are kept.
   assign rd_illegal = !csr_ack_i || (op_q == 2'b00) ||
                       (RO_CHECK && wr_q && (addr_q[11:10] == 2'b11));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         addr_q    <= 12'd0;
         op_q      <= 2'd0;
         wdata_q   <= 32'd0;
         wr_q      <= 1'b0;
         illegal_q <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         op_q      <= op_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         illegal_q <= illegal_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      op_d      = op_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      illegal_d = illegal_q;
      rdata_d   = rdata_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  state_d = S_READ;
                  addr_d  = req_addr_i;
                  op_d    = req_funct3_i[1:0];
                  wdata_d = req_funct3_i[2] ? {27'd0, req_rs1_idx_i} : req_rs1_i;
                  wr_d    = (req_funct3_i[1:0] == 2'b01) || (req_rs1_idx_i != 5'd0);
               end
            end
            S_READ: begin
               illegal_d = rd_illegal;
               rdata_d   = rd_illegal ? 32'd0 : csr_value_i;
               state_d   = (wr_q && !rd_illegal) ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
               if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready_o = (state_q == S_IDLE);
      rsp_valid_o = 1'b0;
      csr_en_o    = 1'b0;
      csr_set_o   = 32'd0;
      csr_clear_o = 32'd0;
      case (state_q)
         S_READ: csr_en_o = !flush_i;
         S_WRITE: begin
            if (!flush_i) begin
               csr_en_o = 1'b1;
               case (op_q)
                  2'b01: begin
                     csr_set_o   = wdata_q;
                     csr_clear_o = ~wdata_q;
                  end
                  2'b10: csr_set_o   = wdata_q;
                  2'b11: csr_clear_o = wdata_q;
                  default: ;
               endcase
            end
         end
         S_RESP: rsp_valid_o = !flush_i;
         default: ;
      endcase
   end

   assign rsp_rdata_o   = rdata_q;
   assign rsp_illegal_o = illegal_q;
   assign csr_addr_o    = addr_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: a small CSR bank model on the bus side, directed spec cases
// and randomized instructions checked against an instruction-level reference model.
module tb_csr_access_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [11:0] req_addr_i = 12'd0;
   logic [2:0]  req_funct3_i = 3'd0;
   logic [4:0]  req_rs1_idx_i = 5'd0;
   logic [31:0] req_rs1_i = 32'd0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_rdata_o;
   logic        rsp_illegal_o;
   logic        csr_en_o;
   logic [11:0] csr_addr_o;
   logic [31:0] csr_set_o;
   logic [31:0] csr_clear_o;
   logic        csr_ack_i;
   logic [31:0] csr_value_i;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   csr_access_unit #(.RO_CHECK(1'b1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_funct3_i(req_funct3_i),
      .req_rs1_idx_i(req_rs1_idx_i), .req_rs1_i(req_rs1_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_illegal_o(rsp_illegal_o),
      .csr_en_o(csr_en_o), .csr_addr_o(csr_addr_o),
      .csr_set_o(csr_set_o), .csr_clear_o(csr_clear_o),
      .csr_ack_i(csr_ack_i), .csr_value_i(csr_value_i)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   // CSR bank: each implemented field applies value <= (value & ~clear) | set when enabled
   localparam int NB = 6;
   localparam logic [11:0] IMPL_ADDR [NB] = '{12'h300, 12'h341, 12'h305, 12'hC00, 12'hF11, 12'h340};
   localparam logic [31:0] BANK_INIT [NB] = '{32'h0000_1888, 32'h0000_0010, 32'h0000_0100,
                                              32'hC0C0_0001, 32'h0000_0001, 32'h1234_5678};
   logic [31:0] bank [NB];

   always @(posedge clk_i) begin
      for (int i = 0; i < NB; i++) begin
         if (rst_i) bank[i] <= BANK_INIT[i];
         else if (csr_en_o && csr_addr_o == IMPL_ADDR[i])
            bank[i] <= (bank[i] & ~csr_clear_o) | csr_set_o;
      end
   end

   always_comb begin
      csr_ack_i   = 1'b0;
      csr_value_i = 32'd0;
      if (csr_en_o) begin
         for (int i = 0; i < NB; i++) begin
            if (csr_addr_o == IMPL_ADDR[i]) begin
               csr_ack_i   = 1'b1;
               csr_value_i = csr_value_i | bank[i];
            end
         end
      end
   end

   function automatic int find_idx(input logic [11:0] a);
      int r;
      r = -1;
      for (int i = 0; i < NB; i++) if (IMPL_ADDR[i] == a) r = i;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
      check({tag, "_rspv"}, {31'd0, rsp_valid_o}, 32'd0);
      check({tag, "_rdata"}, rsp_rdata_o, 32'd0);
      check({tag, "_ill"}, {31'd0, rsp_illegal_o}, 32'd0);
      check({tag, "_en"}, {31'd0, csr_en_o}, 32'd0);
      check({tag, "_addr"}, {20'd0, csr_addr_o}, 32'd0);
      check({tag, "_set"}, csr_set_o, 32'd0);
      check({tag, "_clr"}, csr_clear_o, 32'd0);
   endtask

   // mode: 0 normal, 1 flush in the last bus cycle, 2 reset in WRITE, 3 flush in RESP
   task automatic run_op(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] idx,
                         input logic [31:0] rs1, input int mode, input int hold);
      int          bi;
      logic        ack, is_rw, is_rs, is_rc, wr, ill, do_write, fl;
      logic [31:0] old, w, nv, e_set, e_clr, got_rdata;
      bi       = find_idx(a);
      ack      = (bi >= 0);
      old      = ack ? bank[bi] : 32'd0;
      w        = f3[2] ? {27'd0, idx} : rs1;
      is_rw    = (f3 == 3'b001) || (f3 == 3'b101);
      is_rs    = (f3 == 3'b010) || (f3 == 3'b110);
      is_rc    = (f3 == 3'b011) || (f3 == 3'b111);
      wr       = is_rw || (idx != 5'd0);
      ill      = !ack || !(is_rw || is_rs || is_rc) || (wr && a[11:10] == 2'b11);
      do_write = wr && !ill;
      nv       = !do_write ? old : is_rw ? w : is_rs ? (old | w) : (old & ~w);
      e_set    = (is_rw || is_rs) ? w : 32'd0;
      e_clr    = is_rw ? ~w : is_rc ? w : 32'd0;
      exp_q.push_back(ill ? 32'd0 : old);

      @(negedge clk_i);
      req_valid_i = 1'b1; req_addr_i = a; req_funct3_i = f3;
      req_rs1_idx_i = idx; req_rs1_i = rs1; rsp_ready_i = 1'b0;
      #1 check("acc_ready", {31'd0, req_ready_o}, 32'd1);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_addr_i = 12'($urandom); req_rs1_i = $urandom; req_rs1_idx_i = 5'($urandom);
      fl = (mode == 1) && !do_write;
      flush_i = fl;
      #1;
      check("rd_en", {31'd0, csr_en_o}, {31'd0, !fl});
      check("rd_set", csr_set_o, 32'd0);
      check("rd_clr", csr_clear_o, 32'd0);
      check("rd_addr", {20'd0, csr_addr_o}, {20'd0, a});
      check("rd_rspv", {31'd0, rsp_valid_o}, 32'd0);
      check("rd_ready", {31'd0, req_ready_o}, 32'd0);
      if (fl) begin
         @(negedge clk_i); flush_i = 1'b0; #1;
         check("flrd_rspv", {31'd0, rsp_valid_o}, 32'd0);
         check("flrd_ready", {31'd0, req_ready_o}, 32'd1);
         void'(exp_q.pop_front());
         return;
      end
      if (do_write) begin
         @(negedge clk_i);
         flush_i = (mode == 1);
         rst_i   = (mode == 2);
         #1;
         check("wr_en", {31'd0, csr_en_o}, {31'd0, mode != 1});
         check("wr_set", csr_set_o, (mode == 1) ? 32'd0 : e_set);
         check("wr_clr", csr_clear_o, (mode == 1) ? 32'd0 : e_clr);
         if (mode == 1) begin
            @(negedge clk_i); flush_i = 1'b0; #1;
            check("flwr_rspv", {31'd0, rsp_valid_o}, 32'd0);
            check("flwr_ready", {31'd0, req_ready_o}, 32'd1);
            check("flwr_csr", bank[bi], old);
            void'(exp_q.pop_front());
            return;
         end
         if (mode == 2) begin
            @(negedge clk_i); rst_i = 1'b0; #1;
            check_reset_outs("rstwr");
            void'(exp_q.pop_front());
            return;
         end
      end
      @(negedge clk_i);
      if (mode == 3) begin
         flush_i = 1'b1; #1;
         check("flrsp_rspv", {31'd0, rsp_valid_o}, 32'd0);
         @(negedge clk_i); flush_i = 1'b0; #1;
         check("flrsp_rspv2", {31'd0, rsp_valid_o}, 32'd0);
         check("flrsp_ready", {31'd0, req_ready_o}, 32'd1);
         void'(exp_q.pop_front());
         return;
      end
      #1;
      got_rdata = exp_q.pop_front();
      check("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("rsp_rdata", rsp_rdata_o, got_rdata);
      check("rsp_ill", {31'd0, rsp_illegal_o}, {31'd0, ill});
      check("rsp_ready", {31'd0, req_ready_o}, 32'd0);
      check("rsp_en", {31'd0, csr_en_o}, 32'd0);
      if (ack) check("csr_val", bank[bi], nv);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_i); #1;
         check("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
         check("hold_rdata", rsp_rdata_o, got_rdata);
         check("hold_ill", {31'd0, rsp_illegal_o}, {31'd0, ill});
         check("hold_ready", {31'd0, req_ready_o}, 32'd0);
      end
      @(negedge clk_i); rsp_ready_i = 1'b1;
      @(negedge clk_i); rsp_ready_i = 1'b0; #1;
      check("done_rspv", {31'd0, rsp_valid_o}, 32'd0);
      check("done_ready", {31'd0, req_ready_o}, 32'd1);
   endtask

   localparam logic [11:0] RAND_ADDR [8] = '{12'h300, 12'h341, 12'h305, 12'hC00,
                                             12'hF11, 12'h340, 12'h7C0, 12'h0F1};

   initial begin
      logic [4:0] ridx;
      repeat (2) @(negedge clk_i);
      #1 check_reset_outs("reset");
      @(negedge clk_i); rst_i = 1'b0;

      run_op(12'h341, 3'b001, 5'd5, 32'h8000_0104, 0, 0);
      run_op(12'h300, 3'b010, 5'd0, 32'hFFFF_FFFF, 0, 0);
      run_op(12'h300, 3'b111, 5'h08, 32'd0, 0, 0);
      run_op(12'h7C0, 3'b001, 5'd3, 32'h1234_0000, 0, 0);
      run_op(12'hC00, 3'b001, 5'd3, 32'h0000_ABCD, 0, 0);
      run_op(12'h341, 3'b001, 5'd7, 32'hDEAD_BEEF, 1, 0);
      run_op(12'h305, 3'b010, 5'd2, 32'h0000_00F0, 0, 4);
      run_op(12'h300, 3'b010, 5'd0, 32'd0, 1, 0);
      run_op(12'h305, 3'b011, 5'd9, 32'h0000_0010, 3, 0);
      run_op(12'h300, 3'b000, 5'd1, 32'h5, 0, 0);

      // request together with flush in IDLE is not accepted
      @(negedge clk_i);
      req_valid_i = 1'b1; req_addr_i = 12'h300; req_funct3_i = 3'b001; flush_i = 1'b1;
      #1 check("idleflush_en", {31'd0, csr_en_o}, 32'd0);
      @(negedge clk_i); req_valid_i = 1'b0; flush_i = 1'b0; #1;
      check("idleflush_en2", {31'd0, csr_en_o}, 32'd0);
      check("idleflush_ready", {31'd0, req_ready_o}, 32'd1);

      run_op(12'h340, 3'b001, 5'd1, 32'hCAFE_F00D, 2, 0);

      for (int n = 0; n < 40; n++) begin
         ridx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         run_op(RAND_ADDR[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), ridx,
                $urandom, 0, $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
